// File: rtl/ts_failover_ctrl_if.sv
// rtl/ts_failover_ctrl_if.sv - lane inputs and forwarded TS stream of ts_failover_ctrl
// master drives the four recovered lanes and observes the stream; slave is the scheduler side.
interface ts_failover_ctrl_if;
  logic [7:0] byte_in0;
  logic [7:0] byte_in1;
  logic [7:0] byte_in2;
  logic [7:0] byte_in3;
  logic [3:0] lock_in;
  logic [3:0] sof_in;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       sof_out;

  modport master (
    output byte_in0, byte_in1, byte_in2, byte_in3, lock_in, sof_in,
    input  byte_out, byte_valid, sof_out
  );

  modport slave (
    input  byte_in0, byte_in1, byte_in2, byte_in3, lock_in, sof_in,
    output byte_out, byte_valid, sof_out
  );
endinterface

// File: rtl/ts_failover_ctrl.sv
// rtl/ts_failover_ctrl.sv - packet-aligned failover scheduler for four MPEG2-TS lanes
// Macro REVERT_EN enables revertive return to a recovered higher-priority lane.
module ts_failover_ctrl #(
  parameter int PKT_LEN      = 188,
`ifdef REVERT_EN
  parameter int HOLDOFF_PKTS = 4,
`endif
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  ts_failover_ctrl_if.slave lanes,
  input  logic              i_force_en,
  input  logic [1:0]        i_force_sel,
  output logic [1:0]        o_sel,
  output logic              o_locked,
  output logic              o_abort,
  output logic [CNT_W-1:0]  o_switch_count
);
  localparam int BCNT_W = $clog2(PKT_LEN + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_SOF, ST_FORWARD} state_t;

  state_t             r_state;
  logic [1:0]         r_sel;
  logic               r_sel_valid;
  logic [BCNT_W-1:0]  r_cnt;
  logic [7:0]         r_byte_out;
  logic               r_byte_valid;
  logic               r_sof_out;
  logic               r_abort;
  logic [CNT_W-1:0]   r_switch_count;

  logic [7:0]         w_bytes [4];
  logic               w_any_lock;
  logic [1:0]         w_prio;
  logic [1:0]         w_hold_tgt;
  logic [1:0]         w_target;

  assign w_bytes[0] = lanes.byte_in0;
  assign w_bytes[1] = lanes.byte_in1;
  assign w_bytes[2] = lanes.byte_in2;
  assign w_bytes[3] = lanes.byte_in3;
  assign w_any_lock = |lanes.lock_in;

  always_comb begin
    w_prio = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (lanes.lock_in[i]) w_prio = 2'(i);
    end
  end

`ifdef REVERT_EN
  localparam int GOOD_W = $clog2(HOLDOFF_PKTS + 1);

  logic [GOOD_W-1:0] r_good [4];
  logic [3:0]        r_in_pkt;

  // A packet is good when lock held from its sof up to the following sof.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst || !lanes.lock_in[i]) begin
        r_good[i]   <= '0;
        r_in_pkt[i] <= 1'b0;
      end else if (lanes.sof_in[i]) begin
        r_in_pkt[i] <= 1'b1;
        if (r_in_pkt[i] && r_good[i] != GOOD_W'(HOLDOFF_PKTS))
          r_good[i] <= r_good[i] + 1'b1;
      end
    end
  end

  always_comb begin
    w_hold_tgt = r_sel;
    for (int i = 3; i >= 0; i--) begin
      if (2'(i) < r_sel && lanes.lock_in[i] && r_good[i] == GOOD_W'(HOLDOFF_PKTS))
        w_hold_tgt = 2'(i);
    end
  end
`else
  assign w_hold_tgt = r_sel;
`endif

  // While the current lane holds lock, priority only matters through the revert path.
  always_comb begin
    if (i_force_en)
      w_target = i_force_sel;
    else if (r_state == ST_FORWARD && lanes.lock_in[r_sel])
      w_target = w_hold_tgt;
    else
      w_target = w_prio;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_sel          <= 2'd0;
      r_sel_valid    <= 1'b0;
      r_cnt          <= '0;
      r_byte_out     <= 8'h00;
      r_byte_valid   <= 1'b0;
      r_sof_out      <= 1'b0;
      r_abort        <= 1'b0;
      r_switch_count <= '0;
    end else begin
      r_byte_out   <= 8'h00;
      r_byte_valid <= 1'b0;
      r_sof_out    <= 1'b0;
      r_abort      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_lock || i_force_en) r_state <= ST_WAIT_SOF;
        end
        ST_WAIT_SOF: begin
          if (!w_any_lock && !i_force_en) begin
            r_state <= ST_IDLE;
          end else if (lanes.sof_in[w_target] && lanes.lock_in[w_target]) begin
            r_state      <= ST_FORWARD;
            r_sel        <= w_target;
            r_sel_valid  <= 1'b1;
            r_byte_out   <= w_bytes[w_target];
            r_byte_valid <= 1'b1;
            r_sof_out    <= 1'b1;
            r_cnt        <= BCNT_W'(1);
            if ((!r_sel_valid || w_target != r_sel) && r_switch_count != '1)
              r_switch_count <= r_switch_count + 1'b1;
          end
        end
        ST_FORWARD: begin
          // r_cnt==0 marks the packet boundary: the next sof must follow with no gap.
          if (r_cnt == '0) begin
            if (w_target == r_sel && lanes.sof_in[r_sel] && lanes.lock_in[r_sel]) begin
              r_byte_out   <= w_bytes[r_sel];
              r_byte_valid <= 1'b1;
              r_sof_out    <= 1'b1;
              r_cnt        <= BCNT_W'(1);
            end else begin
              r_state <= ST_WAIT_SOF;
            end
          end else if (!lanes.lock_in[r_sel] || lanes.sof_in[r_sel]) begin
            r_abort <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_WAIT_SOF;
          end else begin
            r_byte_out   <= w_bytes[r_sel];
            r_byte_valid <= 1'b1;
            r_cnt        <= (r_cnt == BCNT_W'(PKT_LEN - 1)) ? '0 : r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign lanes.byte_out   = r_byte_out;
  assign lanes.byte_valid = r_byte_valid;
  assign lanes.sof_out    = r_sof_out;
  assign o_sel            = r_sel;
  assign o_locked         = (r_state == ST_FORWARD);
  assign o_abort          = r_abort;
  assign o_switch_count   = r_switch_count;
endmodule
